// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB types and constants for the bus arbiter: transfer/burst/response
// encodings, arbiter state encoding and the burst-length lookup.
package ahb_bus_arbiter_pkg;

  localparam int NO_OF_MASTERS = 4;
  localparam int HMASTER_WIDTH = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } ahbTransferEnum;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } ahbBurstEnum;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } ahbRespEnum;

  typedef enum logic [1:0] {
    ARB    = 2'b00,
    BURST  = 2'b01,
    UNDEF  = 2'b10,
    LOCKED = 2'b11
  } ahbArbStateEnum;

  // Beats in a burst; 0 marks the open-ended INCR burst.
  function automatic logic [4:0] burstBeats(input ahbBurstEnum burst);
    logic [4:0] beats;
    case (burst)
      SINGLE:         beats = 5'd1;
      WRAP4, INCR4:   beats = 5'd4;
      WRAP8, INCR8:   beats = 5'd8;
      WRAP16, INCR16: beats = 5'd16;
      INCR:           beats = 5'd0;
      default:        beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant and muxed transfer-status bundle between the master agents,
// the bus multiplexer and the arbiter.
interface ahb_bus_arbiter_if #(
  parameter int NO_OF_MASTERS = ahb_bus_arbiter_pkg::NO_OF_MASTERS,
  parameter int HMASTER_WIDTH = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS)
);
  import ahb_bus_arbiter_pkg::*;

  logic [NO_OF_MASTERS-1:0] hbusreq;
  logic [NO_OF_MASTERS-1:0] hlock;
  ahbTransferEnum           htrans;
  ahbBurstEnum              hburst;
  logic                     hready;
  ahbRespEnum               hresp;
  logic [NO_OF_MASTERS-1:0] hgrant;
  logic [HMASTER_WIDTH-1:0] hmaster;
  logic                     hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hburst, hready, hresp,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready, hresp,
    output hgrant, hmaster, hmastlock
  );

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: first set request scanning circularly
// from ptr_i+1, ending at ptr_i itself.
module ahb_rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  import ahb_bus_arbiter_pkg::*;

  int unsigned cand;
  logic        hit;

  // Unrolled circular scan; the first hit latches valid_o and masks later ones.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    hit     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand          = (int'(ptr_i) + k) % N;
      hit           = ~valid_o & req_i[cand];
      grant_o[cand] = grant_o[cand] | hit;
      idx_o         = hit ? W'(cand) : idx_o;
      valid_o       = valid_o | hit;
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: holds the grant across fixed bursts, INCR bursts
// and locked sequences, and re-arbitrates only when the tracker returns to ARB.
module ahb_bus_arbiter #(
  parameter int NO_OF_MASTERS  = ahb_bus_arbiter_pkg::NO_OF_MASTERS,
  parameter int HMASTER_WIDTH  = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS),
  parameter int DEFAULT_MASTER = 0
) (
  input logic              hclk,
  input logic              hreset,
  ahb_bus_arbiter_if.slave bus
);
  import ahb_bus_arbiter_pkg::*;

  localparam logic [NO_OF_MASTERS-1:0] DEF_GRANT = NO_OF_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [HMASTER_WIDTH-1:0] DEF_IDX   = HMASTER_WIDTH'(DEFAULT_MASTER);

  ahbArbStateEnum           state_q, state_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [HMASTER_WIDTH-1:0] ptr_q;
  logic [NO_OF_MASTERS-1:0] grant_q;
  logic [HMASTER_WIDTH-1:0] gidx_q;
  logic [HMASTER_WIDTH-1:0] hmaster_q;
  logic                     hmastlock_q;

  logic [NO_OF_MASTERS-1:0] win_grant;
  logic [HMASTER_WIDTH-1:0] win_idx;
  logic                     win_valid;

  logic                     beat_ok;
  logic                     new_burst;
  logic                     lock_own;
  logic                     arb_pt;
  logic [4:0]               start_len;
  ahbArbStateEnum           start_state;
  logic [4:0]               start_cnt;

  assign beat_ok   = bus.hready & ((bus.htrans == NONSEQ) | (bus.htrans == SEQ));
  assign new_burst = beat_ok & (bus.htrans == NONSEQ);
  assign lock_own  = bus.hlock[gidx_q];
  assign arb_pt    = bus.hready & (state_d == ARB);

  ahb_rr_picker #(
    .N (NO_OF_MASTERS),
    .W (HMASTER_WIDTH)
  ) u_picker (
    .req_i   (bus.hbusreq),
    .ptr_i   (ptr_q),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // Burst tracker next state: error abort, then burst/undefined hold, then lock.
  always_comb begin
    start_len = burstBeats(bus.hburst);
    if (start_len == 5'd0) begin
      start_state = UNDEF;
      start_cnt   = 5'd0;
    end else if (start_len == 5'd1) begin
      start_state = ARB;
      start_cnt   = 5'd0;
    end else begin
      start_state = BURST;
      start_cnt   = start_len - 5'd1;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.hready) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else if (bus.hresp == ERROR) begin
      state_d = lock_own ? LOCKED : ARB;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        ARB: begin
          state_d = new_burst ? start_state : ARB;
          cnt_d   = new_burst ? start_cnt : 5'd0;
        end
        BURST: begin
          if (new_burst) begin
            state_d = start_state;
            cnt_d   = start_cnt;
          end else if (beat_ok && cnt_q <= 5'd1) begin
            state_d = ARB;
            cnt_d   = 5'd0;
          end else if (beat_ok) begin
            state_d = BURST;
            cnt_d   = cnt_q - 5'd1;
          end else begin
            state_d = BURST;
            cnt_d   = cnt_q;
          end
        end
        UNDEF: begin
          if (new_burst) begin
            state_d = start_state;
            cnt_d   = start_cnt;
          end else if (bus.htrans == IDLE) begin
            state_d = ARB;
            cnt_d   = 5'd0;
          end else begin
            state_d = UNDEF;
            cnt_d   = cnt_q;
          end
        end
        LOCKED: begin
          state_d = lock_own ? LOCKED : ARB;
          cnt_d   = 5'd0;
        end
        default: begin
          state_d = ARB;
          cnt_d   = 5'd0;
        end
      endcase
      state_d = ((state_d == ARB) && lock_own) ? LOCKED : state_d;
    end
  end

  // All state and outputs freeze during wait states; grant moves only at arbitration points.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ARB;
      cnt_q       <= 5'd0;
      ptr_q       <= DEF_IDX;
      grant_q     <= DEF_GRANT;
      gidx_q      <= DEF_IDX;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else if (bus.hready) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hmaster_q   <= gidx_q;
      hmastlock_q <= bus.hlock[gidx_q];
      if (arb_pt && win_valid) begin
        grant_q <= win_grant;
        gidx_q  <= win_idx;
        ptr_q   <= win_idx;
      end else if (arb_pt) begin
        grant_q <= DEF_GRANT;
        gidx_q  <= DEF_IDX;
        ptr_q   <= ptr_q;
      end else begin
        grant_q <= grant_q;
        gidx_q  <= gidx_q;
        ptr_q   <= ptr_q;
      end
    end else begin
      state_q     <= state_q;
      cnt_q       <= cnt_q;
      ptr_q       <= ptr_q;
      grant_q     <= grant_q;
      gidx_q      <= gidx_q;
      hmaster_q   <= hmaster_q;
      hmastlock_q <= hmastlock_q;
    end
  end

  assign bus.hgrant    = grant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter with four masters and DEFAULT_MASTER 0.
module tb_ahb_bus_arbiter;
  import ahb_bus_arbiter_pkg::*;

  logic hclk = 1'b0;
  logic hreset;
  int   total = 0;
  int   bad   = 0;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter_if bus ();

  ahb_bus_arbiter dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  ahbTransferEnum tr_v [13];
  logic           rdy_v[13];
  logic [4:0]     cnt_v[13];

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hreset      = 1'b1;
    bus.hbusreq = 4'b0000;
    bus.hlock   = 4'b0000;
    bus.htrans  = IDLE;
    bus.hburst  = SINGLE;
    bus.hready  = 1'b1;
    bus.hresp   = OKAY;
    cyc();
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.hgrant !== 4'b0001) begin bad++; $display("FAIL reset_hgrant: got %b want 0001", bus.hgrant); end
    total++; if (bus.hmaster !== 2'd0) begin bad++; $display("FAIL reset_hmaster: got %0d want 0", bus.hmaster); end
    total++; if (bus.hmastlock !== 1'b0) begin bad++; $display("FAIL reset_hmastlock: got %b want 0", bus.hmastlock); end
    total++; if (dut.state_q !== ARB) begin bad++; $display("FAIL reset_state: got %0d want 0", dut.state_q); end
    total++; if (dut.cnt_q !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", dut.cnt_q); end
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++; if (bus.hgrant !== 4'b0001 || bus.hmaster !== 2'd0) begin
        bad++; $display("FAIL idle_park[%0d]: got grant %b master %0d want 0001/0", i, bus.hgrant, bus.hmaster);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [1:0] exp_m;
    do_reset();
    bus.hbusreq = 4'b1010;
    bus.htrans  = NONSEQ;
    bus.hburst  = SINGLE;
    for (int i = 0; i < 6; i++) begin
      cyc();
      exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      exp_m = (i == 0) ? 2'd0 : ((i % 2 == 1) ? 2'd1 : 2'd3);
      total++; if (bus.hgrant !== exp_g) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.hgrant, exp_g); end
      total++; if (bus.hmaster !== exp_m) begin bad++; $display("FAIL rr_master[%0d]: got %0d want %0d", i, bus.hmaster, exp_m); end
    end
  endtask

  task automatic test_burst_hold();
    logic [3:0] exp_g;
    do_reset();
    bus.hbusreq = 4'b0100;
    cyc();
    total++; if (bus.hgrant !== 4'b0100) begin bad++; $display("FAIL incr8_setup: got %b want 0100", bus.hgrant); end
    tr_v  = '{NONSEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ};
    rdy_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    cnt_v = '{5'd7, 5'd6, 5'd5, 5'd5, 5'd5, 5'd4, 5'd4, 5'd3, 5'd3, 5'd3, 5'd2, 5'd1, 5'd0};
    bus.hburst = INCR8;
    for (int i = 0; i < 13; i++) begin
      bus.htrans  = tr_v[i];
      bus.hready  = rdy_v[i];
      bus.hbusreq = (i >= 2) ? 4'b0101 : 4'b0100;
      cyc();
      exp_g = (i == 12) ? 4'b0001 : 4'b0100;
      total++; if (bus.hgrant !== exp_g) begin bad++; $display("FAIL incr8_grant[%0d]: got %b want %b", i, bus.hgrant, exp_g); end
      total++; if (dut.cnt_q !== cnt_v[i]) begin bad++; $display("FAIL incr8_count[%0d]: got %0d want %0d", i, dut.cnt_q, cnt_v[i]); end
    end
    total++; if (bus.hmaster !== 2'd2) begin bad++; $display("FAIL incr8_master: got %0d want 2", bus.hmaster); end
    total++; if (dut.state_q !== ARB) begin bad++; $display("FAIL incr8_state: got %0d want 0", dut.state_q); end
  endtask

  task automatic test_lock();
    do_reset();
    bus.hbusreq = 4'b0010; bus.hlock = 4'b0010; bus.htrans = IDLE;
    cyc();
    total++; if (bus.hgrant !== 4'b0010 || bus.hmastlock !== 1'b0) begin
      bad++; $display("FAIL lock_s1: got %b/%b want 0010/0", bus.hgrant, bus.hmastlock);
    end
    bus.hbusreq = 4'b0011; bus.htrans = NONSEQ; bus.hburst = INCR;
    cyc();
    total++; if (bus.hgrant !== 4'b0010 || bus.hmastlock !== 1'b1 || bus.hmaster !== 2'd1) begin
      bad++; $display("FAIL lock_s2: got %b/%b/%0d want 0010/1/1", bus.hgrant, bus.hmastlock, bus.hmaster);
    end
    bus.htrans = SEQ;
    cyc();
    total++; if (bus.hgrant !== 4'b0010 || bus.hmastlock !== 1'b1) begin
      bad++; $display("FAIL lock_s3: got %b/%b want 0010/1", bus.hgrant, bus.hmastlock);
    end
    bus.htrans = IDLE;
    cyc();
    total++; if (bus.hgrant !== 4'b0010 || dut.state_q !== LOCKED) begin
      bad++; $display("FAIL lock_s4: got %b/state %0d want 0010/3", bus.hgrant, dut.state_q);
    end
    bus.hready = 1'b0;
    cyc();
    bus.hlock = 4'b0000;
    cyc();
    total++; if (bus.hgrant !== 4'b0010 || bus.hmastlock !== 1'b1) begin
      bad++; $display("FAIL lock_wait: got %b/%b want 0010/1", bus.hgrant, bus.hmastlock);
    end
    bus.hready = 1'b1;
    cyc();
    total++; if (bus.hgrant !== 4'b0001 || bus.hmastlock !== 1'b0 || dut.state_q !== ARB) begin
      bad++; $display("FAIL lock_release: got %b/%b/state %0d want 0001/0/0", bus.hgrant, bus.hmastlock, dut.state_q);
    end
    bus.hbusreq = 4'b0001;
    cyc();
    total++; if (bus.hmaster !== 2'd0 || bus.hgrant !== 4'b0001) begin
      bad++; $display("FAIL lock_after: got %0d/%b want 0/0001", bus.hmaster, bus.hgrant);
    end
  endtask

  task automatic test_error();
    do_reset();
    bus.hbusreq = 4'b1000;
    cyc();
    bus.hbusreq = 4'b1010; bus.htrans = NONSEQ; bus.hburst = WRAP16;
    cyc();
    bus.htrans = SEQ;
    for (int i = 0; i < 3; i++) cyc();
    total++; if (bus.hgrant !== 4'b1000 || dut.cnt_q !== 5'd12) begin
      bad++; $display("FAIL err_before: got %b/%0d want 1000/12", bus.hgrant, dut.cnt_q);
    end
    bus.hresp = ERROR;
    cyc();
    bus.hresp = OKAY;
    total++; if (bus.hgrant !== 4'b0010) begin bad++; $display("FAIL err_grant: got %b want 0010", bus.hgrant); end
    total++; if (dut.cnt_q !== 5'd0 || dut.state_q !== ARB) begin
      bad++; $display("FAIL err_state: got %0d/%0d want 0/0", dut.cnt_q, dut.state_q);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.hbusreq = 4'b0100;
    cyc();
    bus.hbusreq = 4'b0101; bus.htrans = NONSEQ; bus.hburst = INCR16;
    cyc();
    bus.htrans = SEQ;
    for (int i = 0; i < 5; i++) cyc();
    total++; if (bus.hgrant !== 4'b0100 || dut.cnt_q !== 5'd10) begin
      bad++; $display("FAIL rst16_before: got %b/%0d want 0100/10", bus.hgrant, dut.cnt_q);
    end
    hreset = 1'b1;
    cyc();
    hreset = 1'b0;
    total++; if (bus.hgrant !== 4'b0001 || bus.hmaster !== 2'd0 || bus.hmastlock !== 1'b0) begin
      bad++; $display("FAIL rst16_out: got %b/%0d/%b want 0001/0/0", bus.hgrant, bus.hmaster, bus.hmastlock);
    end
    total++; if (dut.state_q !== ARB || dut.cnt_q !== 5'd0) begin
      bad++; $display("FAIL rst16_state: got %0d/%0d want 0/0", dut.state_q, dut.cnt_q);
    end
    bus.htrans = IDLE;
    cyc();
    total++; if (bus.hgrant !== 4'b0100) begin bad++; $display("FAIL rst16_rearb: got %b want 0100", bus.hgrant); end
  endtask

  initial begin
    hreset      = 1'b1;
    bus.hbusreq = 4'b0000;
    bus.hlock   = 4'b0000;
    bus.htrans  = IDLE;
    bus.hburst  = SINGLE;
    bus.hready  = 1'b1;
    bus.hresp   = OKAY;
    test_reset();
    test_round_robin();
    test_burst_hold();
    test_lock();
    test_error();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Shares one AHB address/data bus among NO_OF_MASTERS requesting managers.
- Grants are round-robin. A grant is never switched mid fixed-length burst or during a locked sequence.
- Drives hgrant, hmaster and hmastlock. It sits between the master agents' request lines and the bus multiplexer that selects haddr/htrans/hwdata.

Parameters:
- NO_OF_MASTERS, 4, number of requesters (≥1).
- HMASTER_WIDTH, (NO_OF_MASTERS==1)?1:$clog2(NO_OF_MASTERS), width of the master index.
- DEFAULT_MASTER, 0, parked owner when nobody requests.

Ports:
- hclk, input, 1, bus clock; all logic on the rising edge.
- hreset, input, 1, synchronous active-high reset.
- hbusreq, input, NO_OF_MASTERS, per-master bus request.
- hlock, input, NO_OF_MASTERS, per-master locked-sequence request.
- htrans, input, 2, muxed transfer type (ahbTransferEnum) of the current owner.
- hburst, input, 3, muxed burst type (ahbBurstEnum).
- hready, input, 1, combined transfer completion.
- hresp, input, 1, combined response (ahbRespEnum).
- hgrant, output, NO_OF_MASTERS, one-hot grant, registered.
- hmaster, output, HMASTER_WIDTH, index of the address-phase owner, registered.
- hmastlock, output, 1, current address phase is locked, registered.

Behaviour:
- Reset (hreset=1 at a clock edge):
  - hgrant = one-hot(DEFAULT_MASTER); hmaster = DEFAULT_MASTER; hmastlock = 0.
  - state = ARB; beat counter = 0; round-robin pointer = DEFAULT_MASTER.
  - Reset asserted mid-burst aborts unconditionally.
- Accepted beat: hready=1 and htrans ∈ {NONSEQ, SEQ}. IDLE and BUSY beats never count.
- Burst length on an accepted NONSEQ:
  - SINGLE = 1; WRAP4/INCR4 = 4; WRAP8/INCR8 = 8; WRAP16/INCR16 = 16; INCR = undefined.
  - Counter is 5 bits.
- States:
  - ARB: re-arbitration permitted. An accepted NONSEQ moves to:
    - BURST with count = len-1, for fixed lengths >1;
    - UNDEF for INCR;
    - stays ARB for SINGLE.
  - BURST: each accepted SEQ decrements the counter. An accepted beat with count==1 returns to ARB on that edge.
  - UNDEF: stays until htrans==IDLE with hready=1, or an accepted NONSEQ (new burst, re-evaluated as in ARB).
  - LOCKED: entered from any state at an arbitration point when hlock[owner]=1. Stays while hlock[owner]=1. Exits to ARB on the first hready=1 cycle with hlock[owner]=0.
- Arbitration point: a cycle with hready=1 in which the next state is ARB.
  - Only then may hgrant change, registered at that edge.
  - Winner: first requester scanning circularly from pointer+1; the pointer updates to the winner.
  - No requester: grant DEFAULT_MASTER, pointer unchanged.
  - Current owner still requesting with no other requester: keeps the grant.
- Priority of simultaneous events:
  1. hreset.
  2. hresp=ERROR with hready=1: burst terminated, counter cleared, state = ARB (or LOCKED if hlock[owner]=1).
  3. Lock.
  4. Burst/undefined hold.
  5. Round-robin.
- hmaster and hmastlock: on any edge with hready=1, hmaster ← index(hgrant) and hmastlock ← hlock[index(hgrant)]. Both hold while hready=0. This gives one hready cycle between the grant change and the address-phase ownership change.
- Wait states (hready=0): state, counter, hgrant, hmaster and hmastlock all frozen.
- NO_OF_MASTERS==1: hgrant constant 1, hmaster constant 0; lock tracking still drives hmastlock.
- hgrant is always exactly one-hot.

Decomposition:
- Add to AhbGlobalPackage:
  - typedef ahbArbStateEnum {ARB, BURST, UNDEF, LOCKED};
  - function burstBeats(ahbBurstEnum) returning a 5-bit length, 0 for INCR.
  - Reuse NO_OF_MASTERS, HMASTER_WIDTH, ahbTransferEnum, ahbBurstEnum, ahbRespEnum.
- One sub-module: ahb_rr_picker. Combinational circular first-one search from pointer+1 over a request vector. Outputs a one-hot winner and its index plus a valid flag.

Test Plan:
- Reset with hbusreq=4'b0000 → hgrant=4'b0001, hmaster=0, hmastlock=0; grant holds for 10 idle cycles.
- Masters 1 and 3 both request continuously, each issuing SINGLE bursts with hready=1 → hgrant alternates 0010/1000 on every accepted beat; hmaster follows one cycle later.
- Master 2 owns the bus and issues INCR8; master 0 requests at beat 3 → hgrant stays 0100 for all 8 accepted beats, including 2 inserted BUSY beats and 3 hready=0 wait cycles; switches to 0001 on the edge accepting beat 8.
- Master 1 runs INCR with hlock[1]=1 while master 0 requests → hgrant stays 0010 and hmastlock=1 until hlock[1] drops and an hready=1 cycle occurs; then hgrant=0001 and hmastlock=0 next edge.
- Master 3 runs WRAP16; hresp=ERROR with hready=1 at beat 5 while master 1 requests → counter cleared and hgrant=0010 at that edge.
- hreset pulsed for 1 cycle mid-INCR16 (beat 7) → next cycle hgrant=0001, hmaster=0, state ARB, counter 0.
